// File: rtl/psum_relu_quant.sv
// Per-lane partial-sum holder with bias/ReLU/shift/saturate activation into a 2-entry FIFO.
// Final beat -> out_vld 2 cycles later; stall raised when FIFO plus in-flight stage reach 2.
module psum_relu_quant #(
  parameter int LANES      = 120,
  parameter int FRAC_SHIFT = 8,
  parameter int BIAS_SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            cfg_num_pass,
  input  logic [7:0]            cfg_groups,
  input  logic [LANES*16-1:0]   bias,
  input  logic [LANES*33-1:0]   result,
  input  logic                  result_vld,
  output logic [LANES*28-1:0]   partial_output,
  output logic                  stall,
  output logic [LANES*16-1:0]   out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_num_pass;
  logic [7:0]            r_groups;
  logic [7:0]            r_pass_cnt;
  logic [7:0]            r_grp_cnt;
  logic [LANES*28-1:0]   r_psum;
  logic                  r_s1_vld;
  logic [LANES*34-1:0]   r_s1;
  logic [LANES*16-1:0]   r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  r_ovf;

  logic                  w_start;
  logic                  w_beat;
  logic                  w_final;
  logic                  w_last_grp;
  logic                  w_pop;
  logic                  w_push_ok;
  logic [LANES*28-1:0]   w_psum_sat;
  logic [LANES*34-1:0]   w_s1_nxt;
  logic [LANES*16-1:0]   w_act;

  assign w_start    = start && (r_state == ST_IDLE);
  assign w_beat     = result_vld && (r_state == ST_RUN);
  assign w_final    = w_beat && (r_pass_cnt == r_num_pass - 8'd1);
  assign w_last_grp = (r_grp_cnt == r_groups - 8'd1);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [32:0] w_res;
    logic [33:0] w_bias_ext;
    logic [33:0] w_s1q;
    logic [33:0] w_shr;

    assign w_res      = result[g*33 +: 33];
    assign w_bias_ext = {{18{bias[g*16+15]}}, bias[g*16 +: 16]};
    // In range only when the bits above the 28-bit field all match the sign.
    assign w_psum_sat[g*28 +: 28] = (w_res[32:27] == {6{w_res[32]}}) ? w_res[27:0] :
                                    (w_res[32] ? 28'h8000000 : 28'h7FFFFFF);
    assign w_s1_nxt[g*34 +: 34]   = {w_res[32], w_res} + (w_bias_ext << BIAS_SHIFT);
    assign w_s1q                  = r_s1[g*34 +: 34];
    assign w_shr                  = w_s1q >> FRAC_SHIFT;
    assign w_act[g*16 +: 16]      = w_s1q[33] ? 16'd0 :
                                    ((w_shr > 34'd32767) ? 16'h7FFF : w_shr[15:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_final && w_last_grp) w_state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        if (!r_s1_vld && (r_count == 2'd0)) begin
          w_state_nxt = ST_IDLE;
          done        = 1'b1;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_pass <= 8'd1;
      r_groups   <= 8'd1;
      r_pass_cnt <= 8'd0;
      r_grp_cnt  <= 8'd0;
      r_psum     <= '0;
    end else if (w_start) begin
      r_num_pass <= (cfg_num_pass == 8'd0) ? 8'd1 : cfg_num_pass;
      r_groups   <= (cfg_groups == 8'd0) ? 8'd1 : cfg_groups;
      r_pass_cnt <= 8'd0;
      r_grp_cnt  <= 8'd0;
      r_psum     <= '0;
    end else if (w_final) begin
      r_pass_cnt <= 8'd0;
      r_grp_cnt  <= r_grp_cnt + 8'd1;
      r_psum     <= '0;
    end else if (w_beat) begin
      r_pass_cnt <= r_pass_cnt + 8'd1;
      r_psum     <= w_psum_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else begin
      r_s1_vld <= w_final;
      if (w_final) r_s1 <= w_s1_nxt;
    end
  end

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop     = out_vld && out_rdy;
  assign w_push_ok = r_s1_vld && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_start) begin
        r_ovf <= 1'b0;
      end else if (r_s1_vld && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
      if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)     r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_act;
  end

  assign out_vld        = (r_count != 2'd0);
  assign out_data       = out_vld ? r_mem[r_rd_ptr] : '0;
  assign partial_output = r_psum;
  assign ovf_err        = r_ovf;
  assign busy           = (r_state != ST_IDLE);
  assign stall          = (({1'b0, r_count} + {2'b00, r_s1_vld}) >= 3'd2);

endmodule

// File: tb/tb_psum_relu_quant.sv
// Bench for psum_relu_quant: directed cases from the activation rules plus randomized tiles against a plain-arithmetic model.
module tb_psum_relu_quant;
  localparam int LANES = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [7:0]            cfg_num_pass;
  logic [7:0]            cfg_groups;
  logic [LANES*16-1:0]   bias;
  logic [LANES*33-1:0]   result;
  logic                  result_vld;
  logic [LANES*28-1:0]   partial_output;
  logic                  stall;
  logic [LANES*16-1:0]   out_data;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  busy;
  logic                  done;
  logic                  ovf_err;

  int n_checks = 0;
  int n_pass   = 0;

  int                    m_np, m_ng, m_pass, m_grp;
  logic [LANES*28-1:0]   m_psum;
  logic [LANES*16-1:0]   m_bias;
  logic [LANES*16-1:0]   exp_q[$];

  always #5 clk = ~clk;

  psum_relu_quant #(.LANES(LANES), .FRAC_SHIFT(8), .BIAS_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_pass(cfg_num_pass), .cfg_groups(cfg_groups),
    .bias(bias), .result(result), .result_vld(result_vld), .partial_output(partial_output),
    .stall(stall), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] m_sat28(input longint v);
    if (v > 134217727)  return 28'h7FFFFFF;
    if (v < -134217728) return 28'h8000000;
    return 28'(v);
  endfunction

  // Activation from the arithmetic definition: bias scaled by 256, ReLU, divide by 256, cap at 32767.
  function automatic logic [15:0] m_act(input longint r, input longint b);
    longint s;
    s = r + b * 256;
    if (s < 0) return 16'd0;
    s = s / 256;
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  function automatic longint lane_res(input logic [LANES*33-1:0] v, input int i);
    logic signed [32:0] x;
    x = v[i*33 +: 33];
    return longint'(x);
  endfunction

  function automatic longint lane_bias(input int i);
    logic signed [15:0] x;
    x = m_bias[i*16 +: 16];
    return longint'(x);
  endfunction

  function automatic logic [LANES*33-1:0] rand_vec();
    logic [LANES*33-1:0] v;
    logic [63:0]         t;
    for (int i = 0; i < LANES; i++) begin
      t = {$urandom(), $urandom()};
      v[i*33 +: 33] = t[32:0];
    end
    return v;
  endfunction

  function automatic logic [LANES*16-1:0] rand_bias();
    logic [LANES*16-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*16 +: 16] = 16'($urandom());
    return v;
  endfunction

  task automatic start_tile(input int np, input int ng, input logic [LANES*16-1:0] b);
    cfg_num_pass = 8'(np);
    cfg_groups   = 8'(ng);
    bias         = b;
    start        = 1'b1;
    step();
    start        = 1'b0;
    m_np   = (np == 0) ? 1 : np;
    m_ng   = (ng == 0) ? 1 : ng;
    m_pass = 0;
    m_grp  = 0;
    m_psum = '0;
    m_bias = b;
  endtask

  task automatic do_beat(input logic [LANES*33-1:0] res);
    logic [LANES*16-1:0] act;
    result     = res;
    result_vld = 1'b1;
    step();
    result_vld = 1'b0;
    if (m_pass == m_np - 1) begin
      for (int i = 0; i < LANES; i++) act[i*16 +: 16] = m_act(lane_res(res, i), lane_bias(i));
      exp_q.push_back(act);
      m_psum = '0;
      m_pass = 0;
      m_grp++;
    end else begin
      for (int i = 0; i < LANES; i++) m_psum[i*28 +: 28] = m_sat28(lane_res(res, i));
      m_pass++;
    end
    check("partial_output", partial_output, m_psum);
  endtask

  task automatic finish_tile();
    int done_cnt;
    int cyc;
    done_cnt = 0;
    cyc      = 0;
    out_rdy  = 1'b1;
    while (busy && cyc < 200) begin
      if (out_vld) begin
        if (exp_q.size() == 0) check("spurious_out_vld", out_vld, 0);
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
      step();
      cyc++;
    end
    check("tile_ended", busy, 0);
    check("done_pulses", done_cnt, 1);
    check("outputs_delivered", exp_q.size(), 0);
    check("out_vld_idle", out_vld, 0);
    out_rdy = 1'b0;
  endtask

  initial begin
    logic [LANES*33-1:0] r;
    logic [LANES*16-1:0] b;
    int                  d;
    int                  gap;

    rst = 1'b1; start = 1'b0; cfg_num_pass = '0; cfg_groups = '0;
    bias = '0; result = '0; result_vld = 1'b0; out_rdy = 1'b0;
    step();
    step();
    check("rst_partial", partial_output, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf_err, 0);
    rst = 1'b0;
    step();

    // Three passes, one group, bias 0: feedback then one activation.
    start_tile(3, 1, '0);
    check("busy_run", busy, 1);
    check("p0_before", partial_output[27:0], 0);
    r = rand_vec(); r[32:0] = 33'd256;  do_beat(r);
    check("p0_beat1", partial_output[27:0], 256);
    r = rand_vec(); r[32:0] = 33'd512;  do_beat(r);
    check("p0_beat2", partial_output[27:0], 512);
    r = rand_vec(); r[32:0] = 33'd1024; do_beat(r);
    check("p0_final_clear", partial_output[27:0], 0);
    check("out_vld_n1", out_vld, 0);
    step();
    check("out_vld_n2", out_vld, 1);
    check("out0_1024", out_data[15:0], 4);
    finish_tile();

    // Saturation of the feedback and of the activation.
    start_tile(2, 1, '0);
    r = rand_vec(); r[32:0] = 33'h0_4000_0000; r[65:33] = 33'h1_C000_0000;
    do_beat(r);
    check("sat_pos", partial_output[27:0], 28'h7FFFFFF);
    check("sat_neg", partial_output[55:28], 28'h8000000);
    r = rand_vec(); r[32:0] = 33'h0_FFFF_FFFF;
    do_beat(r);
    step();
    check("act_sat", out_data[15:0], 16'h7FFF);
    finish_tile();

    // ReLU and bias on separate lanes.
    b = rand_bias(); b[15:0] = 16'd1; b[31:16] = 16'd0; b[47:32] = 16'hFFFE;
    start_tile(1, 1, b);
    r = rand_vec(); r[32:0] = 33'(-100); r[65:33] = 33'(-1000); r[98:66] = 33'd5000;
    do_beat(r);
    step();
    check("relu_bias_pos", out_data[15:0], 0);
    check("relu_neg", out_data[31:16], 0);
    check("bias_neg", out_data[47:32], 17);
    finish_tile();

    // Backpressure and overflow.
    start_tile(1, 4, rand_bias());
    do_beat(rand_vec());
    check("stall_one", stall, 0);
    do_beat(rand_vec());
    check("stall_two", stall, 1);
    do_beat(rand_vec());
    check("ovf_before_drop", ovf_err, 0);
    step();
    check("ovf_set", ovf_err, 1);
    check("stall_full", stall, 1);
    void'(exp_q.pop_back());
    out_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("drain_vld", out_vld, 1);
      check("drain_data", out_data, exp_q.pop_front());
      step();
    end
    out_rdy = 1'b0;
    check("drain_empty", out_vld, 0);
    check("ovf_sticky", ovf_err, 1);
    do_beat(rand_vec());
    finish_tile();

    // Zero config means one pass, one group; start clears ovf_err.
    start_tile(0, 0, rand_bias());
    check("ovf_cleared", ovf_err, 0);
    do_beat(rand_vec());
    finish_tile();

    // start during RUN must not reload or clear anything.
    start_tile(2, 1, rand_bias());
    do_beat(rand_vec());
    cfg_num_pass = 8'd1; cfg_groups = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_psum", partial_output, m_psum);
    check("start_ignored_busy", busy, 1);
    do_beat(rand_vec());
    finish_tile();

    // Asynchronous reset mid-tile with data in the FIFO.
    start_tile(2, 3, rand_bias());
    do_beat(rand_vec());
    do_beat(rand_vec());
    do_beat(rand_vec());
    step();
    check("pre_reset_vld", out_vld, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_partial", partial_output, 0);
    check("arst_out_vld", out_vld, 0);
    check("arst_out_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_stall", stall, 0);
    check("arst_done", done, 0);
    step();
    rst = 1'b0;
    exp_q.delete();
    d = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) d++;
      step();
    end
    check("no_done_after_reset", d, 0);

    // Randomized tiles.
    for (int t = 0; t < 8; t++) begin
      start_tile($urandom_range(1, 4), $urandom_range(1, 2), rand_bias());
      for (int g = 0; g < m_ng; g++) begin
        for (int p = 0; p < m_np; p++) begin
          do_beat(rand_vec());
          gap = $urandom_range(0, 2);
          for (int k = 0; k < gap; k++) step();
          if (gap > 0) check("psum_hold", partial_output, m_psum);
        end
      end
      finish_tile();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
